// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: sequences one Full_adder cell LSB-first over WIDTH-bit operands.
// Optional signed-overflow output ovf is built only when SERIAL_ADDER_OVF_EN is defined.

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             cell_sum, cell_carry;
  logic             last_bit;

  Full_adder u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .cin   (carry_q),
    .sum   (cell_sum),
    .carry (cell_carry)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets a default first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      s_sh    <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_q <= cin;
            cnt     <= '0;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          s_sh    <= {cell_sum, s_sh[WIDTH-1:1]};
          carry_q <= cell_carry;
          cnt     <= cnt + 1'b1;
          // Result is published straight from the cell on the final bit, not from s_sh.
          if (last_bit) begin
            sum  <= {cell_sum, s_sh[WIDTH-1:1]};
            cout <= cell_carry;
`ifdef SERIAL_ADDER_OVF_EN
            ovf  <= carry_q ^ cell_carry;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

module Full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed cases plus a random sweep against an arithmetic model.
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             busy, done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Plain integer arithmetic: unsigned sum for {cout,sum}, signed range test for overflow.
  function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
    res_t        r;
    int unsigned u;
    int          s;
    u = int'(x) + int'(y) + int'(c);
    s = int'($signed(x)) + int'($signed(y)) + int'(c);
    r.sum  = u[WIDTH-1:0];
    r.cout = u[WIDTH];
    r.ovf  = (s > (2 ** (WIDTH - 1)) - 1) || (s < -(2 ** (WIDTH - 1)));
    return r;
  endfunction

  task automatic check_result(input string tag, input res_t exp);
    check({tag, " sum"}, 64'(sum), 64'(exp.sum));
    check({tag, " cout"}, 64'(cout), 64'(exp.cout));
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, " ovf"}, 64'(ovf), 64'(exp.ovf));
`endif
  endtask

  // One full operation; operands are scrambled right after acceptance to prove they were captured.
  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c, input string tag);
    res_t exp;
    int   n;
    bit   seen;
    exp = model(x, y, c);
    @(negedge clk);
    a = x; b = y; cin = c; start = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
      end
      if (done) seen = 1'b1;
    end
    check({tag, " done_seen"}, 64'(seen), 64'd1);
    check({tag, " latency"}, 64'(n), 64'(WIDTH + 1));
    check_result(tag, exp);
    @(posedge clk); #1;
    check({tag, " done_single"}, 64'(done), 64'd0);
  endtask

  initial begin
    res_t exp;
    int   ndone, first, last;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset sum", 64'(sum), 64'd0);
    check("reset cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("reset ovf", 64'(ovf), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    run_op(8'h5A, 8'h3C, 1'b0, "op_5a_3c");
    run_op(8'hFF, 8'h01, 1'b0, "op_ff_01");
    run_op(8'hFF, 8'hFF, 1'b1, "op_ff_ff_c");

    // Start pulsed mid-RUN with different operands must be ignored.
    exp = model(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    ndone = 0; first = 0;
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk); #1;
      if (i == 1) start = 1'b0;
      if (i == 3) begin start = 1'b1; a = 8'hF0; b = 8'h0F; cin = 1'b1; end
      if (i == 4) start = 1'b0;
      if (done) begin
        ndone++;
        if (first == 0) first = i;
      end
    end
    check("ignore ndone", 64'(ndone), 64'd1);
    check("ignore latency", 64'(first), 64'(WIDTH + 1));
    check_result("ignore", exp);
    check("ignore idle busy", 64'(busy), 64'd0);

    // Reset mid-RUN discards everything and suppresses done.
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst sum", 64'(sum), 64'd0);
    check("rst cout", 64'(cout), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("rst no_done", 64'(ndone), 64'd0);
    run_op(8'h01, 8'h02, 1'b0, "post_rst");

    // Start held high: one result every WIDTH+2 cycles, busy and done never together.
    exp = model(8'h21, 8'h43, 1'b1);
    @(negedge clk);
    a = 8'h21; b = 8'h43; cin = 1'b1; start = 1'b1;
    ndone = 0; first = 0; last = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      check($sformatf("held overlap c%0d", i), 64'(busy & done), 64'd0);
      if (done) begin
        ndone++;
        check_result($sformatf("held d%0d", ndone), exp);
        if (last != 0) check($sformatf("held period d%0d", ndone), 64'(i - last), 64'(WIDTH + 2));
        else first = i;
        last = i;
      end
    end
    start = 1'b0;
    check("held ndone", 64'(ndone), 64'd3);
    check("held first", 64'(first), 64'(WIDTH + 1));
    repeat (2) @(posedge clk);

    for (int k = 0; k < 1000; k++)
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), $sformatf("rand%0d", k));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that sequences a single one-bit full-adder cell over multi-bit operands. It accepts a WIDTH-bit addition request with a start pulse and feeds operand bits LSB-first through the `Full_adder` cell, one bit per clock, holding the carry in a flip-flop between bits. When the last bit is done, it presents the registered WIDTH-bit sum and carry-out with a one-cycle done pulse. It sits between a requesting sequencer and the shared one-bit adder cell, trading latency for area.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start.
- b  input  WIDTH  operand B; captured on the accepted start.
- cin  input  1  initial carry-in; captured on the accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; sum/cout/ovf valid.
- sum  output  WIDTH  result; held until the next accepted start.
- cout  output  1  carry out of the MSB; held with sum.
- ovf  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- The block instantiates one `Full_adder` cell (a, b, cin -> sum, carry).
  - Cell inputs: a_sh[0], b_sh[0], carry_q.
- Internal registers:
  - a_sh, b_sh: WIDTH-bit operand shift registers.
  - carry_q: 1-bit carry flip-flop.
  - s_sh: WIDTH-bit result shift register.
  - cnt: bit counter, $clog2(WIDTH+1) bits.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1, load a_sh=a, b_sh=b, carry_q=cin, cnt=0, and go to RUN.
  - On start=0, stay in IDLE.
- RUN, each clock:
  - Shift a_sh and b_sh right by 1.
  - Shift the cell's sum into s_sh at the MSB (right shift).
  - carry_q <= cell carry; cnt <= cnt+1.
  - When cnt==WIDTH-1 on this edge, go to DONE.
  - On that same edge: sum <= final s_sh value (bit WIDTH-1 = current cell sum), cout <= cell carry.
- DONE: done=1 for exactly this cycle; go to IDLE on the next edge unconditionally.
- start is ignored in RUN and DONE. There is no queueing; the requester must retry.
- a, b and cin may change freely after the accepted start without affecting the result.
- Arithmetic: {cout,sum} = a + b + cin, computed modulo 2^(WIDTH+1) with no truncation of carry.

## Timing
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, cnt=0, carry_q=0, and all shift registers 0.
- start accepted at edge T: busy=1 from T until edge T+WIDTH.
- done=1 in the cycle following edge T+WIDTH.
  - Total latency from start to done is WIDTH+1 cycles.
  - Back-to-back throughput is one operation per WIDTH+2 cycles.
- sum/cout/ovf update only at edge T+WIDTH, then stay stable until the next operation's completion edge.
- busy and done are never high together.
- rst asserted mid-RUN: everything returns immediately to reset values. No done pulse is produced and the partial result is discarded.
- After rst deassertion, the first start sampled in IDLE is accepted normally.
- start held high continuously: a new operation is accepted on each IDLE cycle, i.e. every WIDTH+2 cycles.

## Configuration
- Macro SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output ovf.
  - ovf = (carry into MSB) XOR cout. The carry into the MSB is carry_q at the final RUN edge.
  - ovf registers at the same edge as sum and resets to 0.
- Undefined:
  - The ovf port and its logic are absent.
  - All other behaviour and timing are identical.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0 -> sum=0x96, cout=0, ovf=1; done exactly 9 cycles after start.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1, ovf=0.
- start pulsed at cycle 3 of RUN, with different operands -> ignored: first result unchanged, single done pulse, next accept only after IDLE.
- rst asserted after 4 RUN cycles -> busy=0, sum=0x00, no done. A new start of 0x01+0x02 then gives sum=0x03 after 9 cycles.
- start held high for 30 cycles with fixed operands -> done pulses every 10 cycles (WIDTH+2); busy/done never overlap.
- Random sweep, 1000 operand pairs plus cin -> {cout,sum} matches a+b+cin for every pair.
